// File: rtl/bd_pin_pkg.sv
// Shared widths and FSM state types for the BD pin model.
package bd_pin_pkg;

  localparam int NUM_BITS_PIN2CORE = 21;
  localparam int NUM_BITS_CORE2PIN = 34;

  typedef enum logic {
    RX_READY,
    RX_WAIT_LOW
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_VALID
  } tx_state_t;

endpackage

// File: rtl/bd_pin_if.sv
// Pin-side and core-side channels of the BD pin model.
// The master modport is the FPGA/core side; the slave modport is the model.
interface bd_pin_if
  import bd_pin_pkg::*;
#(
  parameter int IN_W  = NUM_BITS_PIN2CORE,
  parameter int OUT_W = NUM_BITS_CORE2PIN,
  parameter int CNT_W = 3
);

  logic             pin_in_valid;
  logic [IN_W-1:0]  pin_in_data;
  logic             pin_in_ready;
  logic             pin_out_valid;
  logic [OUT_W-1:0] pin_out_data;
  logic             pin_out_ready;
  logic             rx_v;
  logic [IN_W-1:0]  rx_d;
  logic             rx_a;
  logic             tx_v;
  logic [OUT_W-1:0] tx_d;
  logic             tx_a;
  logic [CNT_W-1:0] rx_count;

  modport master (
    output pin_in_valid, pin_in_data, pin_out_ready, rx_a, tx_v, tx_d,
    input  pin_in_ready, pin_out_valid, pin_out_data, rx_v, rx_d, tx_a, rx_count
  );

  modport slave (
    input  pin_in_valid, pin_in_data, pin_out_ready, rx_a, tx_v, tx_d,
    output pin_in_ready, pin_out_valid, pin_out_data, rx_v, rx_d, tx_a, rx_count
  );

endinterface

// File: rtl/bd_pin_fifo.sv
// Registered-pointer FIFO with occupancy count; head word is visible on o_data.
module bd_pin_fifo
  import bd_pin_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bd_pin_model.sv
// BD side of the FPGA<->BD pin link: RX terminator with FIFO, TX source.
// Define BD_MODEL_SYNC_EN to put 2-flop synchronizers on pin_in_valid/pin_out_ready.
//
// state       | meaning
// RX_READY    | ready high, next valid pushes the pin word
// RX_WAIT_LOW | ready low, waiting for valid low and FIFO space
// TX_IDLE     | valid low, waiting for tx_v
// TX_SETUP    | data driven, valid low, waiting for ready
// TX_VALID    | valid high until ready drops
module bd_pin_model
  import bd_pin_pkg::*;
#(
  parameter int NUM_BITS_IN  = NUM_BITS_PIN2CORE,
  parameter int NUM_BITS_OUT = NUM_BITS_CORE2PIN,
  parameter int RX_DEPTH     = 4
) (
  input  logic    clk,
  input  logic    reset,
  bd_pin_if.slave bd
);

  localparam int CNT_W = $clog2(RX_DEPTH) + 1;

  logic w_vin;
  logic w_rin;

`ifdef BD_MODEL_SYNC_EN
  logic [1:0] r_vin_sync;
  logic [1:0] r_rin_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vin_sync <= '0;
      r_rin_sync <= '0;
    end else begin
      r_vin_sync <= {r_vin_sync[0], bd.pin_in_valid};
      r_rin_sync <= {r_rin_sync[0], bd.pin_out_ready};
    end
  end

  assign w_vin = r_vin_sync[1];
  assign w_rin = r_rin_sync[1];
`else
  assign w_vin = bd.pin_in_valid;
  assign w_rin = bd.pin_out_ready;
`endif

  rx_state_t         r_rx_state;
  logic              r_pin_in_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [NUM_BITS_IN-1:0] w_head;

  assign w_push = (r_rx_state == RX_READY) && w_vin;
  assign w_pop  = bd.rx_a && !w_empty;

  bd_pin_fifo #(
    .WIDTH (NUM_BITS_IN),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bd.pin_in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A pop on the same edge frees a slot, so ready may reopen from a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state     <= RX_WAIT_LOW;
      r_pin_in_ready <= 1'b0;
    end else begin
      case (r_rx_state)
        RX_READY: begin
          if (w_vin) begin
            r_rx_state     <= RX_WAIT_LOW;
            r_pin_in_ready <= 1'b0;
          end
        end
        RX_WAIT_LOW: begin
          if (!w_vin && (!w_full || w_pop)) begin
            r_rx_state     <= RX_READY;
            r_pin_in_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  tx_state_t               r_tx_state;
  logic                    r_pin_out_valid;
  logic [NUM_BITS_OUT-1:0] r_pin_out_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state      <= TX_IDLE;
      r_pin_out_valid <= 1'b0;
      r_pin_out_data  <= '0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (bd.tx_v) begin
            r_pin_out_data <= bd.tx_d;
            r_tx_state     <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          if (w_rin) begin
            r_tx_state      <= TX_VALID;
            r_pin_out_valid <= 1'b1;
          end
        end
        TX_VALID: begin
          if (!w_rin) begin
            r_tx_state      <= TX_IDLE;
            r_pin_out_valid <= 1'b0;
          end
        end
        default: begin
          r_tx_state      <= TX_IDLE;
          r_pin_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bd.pin_in_ready  = r_pin_in_ready;
  assign bd.pin_out_valid = r_pin_out_valid;
  assign bd.pin_out_data  = r_pin_out_data;
  assign bd.rx_v          = !w_empty;
  assign bd.rx_d          = w_head;
  assign bd.rx_count      = w_count;
  assign bd.tx_a          = (r_tx_state == TX_IDLE) && bd.tx_v;

endmodule

// File: tb/tb_bd_pin_model.sv
// Scoreboard bench for bd_pin_model: RX words and TX words are queued when driven
// and checked when the model delivers them.
module tb_bd_pin_model;
  import bd_pin_pkg::*;

  localparam int IN_W  = NUM_BITS_PIN2CORE;
  localparam int OUT_W = NUM_BITS_CORE2PIN;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef BD_MODEL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  bd_pin_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  bd_pin_model #(
    .NUM_BITS_IN  (IN_W),
    .NUM_BITS_OUT (OUT_W),
    .RX_DEPTH     (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bd    (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [IN_W-1:0]  rx_q[$];
  logic [OUT_W-1:0] tx_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && bus.pin_in_ready !== 1'b1; i++) tick();
    chk("rx_ready_wait", bus.pin_in_ready, 1);
  endtask

  task automatic rx_pop_begin();
    if (rx_q.size() == 0) chk("rx_v_unexpected", bus.rx_v, 0);
    else begin
      chk("rx_v", bus.rx_v, 1);
      chk("rx_d", bus.rx_d, rx_q.pop_front());
    end
    bus.rx_a = 1'b1;
  endtask

  task automatic rx_pop();
    rx_pop_begin();
    tick();
    bus.rx_a = 1'b0;
  endtask

  // Sends one word on the FPGA->BD pins; optionally pops the head on the push edge.
  task automatic pin_send(input logic [IN_W-1:0] d, input bit pop_on_push, input int hold);
    int n;
    wait_ready();
    bus.pin_in_valid = 1'b1;
    bus.pin_in_data  = d;
    rx_q.push_back(d);
    repeat (LAT) tick();
    if (pop_on_push) rx_pop_begin();
    tick();
    bus.rx_a = 1'b0;
    n = LAT + 1;
    while (bus.pin_in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("rx_push_lat", n, LAT + 1);
    if (hold > 0) begin
      repeat (hold) tick();
      chk("rx_ready_hold", bus.pin_in_ready, 0);
    end
    bus.pin_in_valid = 1'b0;
  endtask

  task automatic tx_send(input logic [OUT_W-1:0] d, input bit rdy_late);
    int n;
    bus.pin_out_ready = !rdy_late;
    repeat (LAT + 1) tick();
    bus.tx_v = 1'b1;
    bus.tx_d = d;
    #1;
    chk("tx_a_hi", bus.tx_a, 1);
    tx_q.push_back(d);
    tick();
    bus.tx_v = 1'b0;
    #1;
    chk("tx_a_lo", bus.tx_a, 0);
    chk("tx_setup_valid", bus.pin_out_valid, 0);
    chk("tx_setup_data", bus.pin_out_data, d);
    if (rdy_late) begin
      repeat (3) tick();
      chk("tx_wait_rdy_valid", bus.pin_out_valid, 0);
      bus.pin_out_ready = 1'b1;
    end
    n = 0;
    while (bus.pin_out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("tx_valid_lat", n, rdy_late ? LAT + 1 : 1);
    chk("tx_d", bus.pin_out_data, tx_q.pop_front());
    bus.pin_out_ready = 1'b0;
    n = 0;
    while (bus.pin_out_valid !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("tx_drop_lat", n, LAT + 1);
    chk("tx_d_hold", bus.pin_out_data, d);
  endtask

  initial begin
    logic [IN_W-1:0] w;
    int n;
    bus.pin_in_valid  = 1'b0;
    bus.pin_in_data   = '0;
    bus.pin_out_ready = 1'b0;
    bus.rx_a          = 1'b0;
    bus.tx_v          = 1'b0;
    bus.tx_d          = '0;
    #2 reset = 1'b1;
    repeat (3) tick();

    chk("rst_pin_in_ready", bus.pin_in_ready, 0);
    chk("rst_pin_out_valid", bus.pin_out_valid, 0);
    chk("rst_pin_out_data", bus.pin_out_data, 0);
    chk("rst_rx_v", bus.rx_v, 0);
    chk("rst_rx_count", bus.rx_count, 0);
    chk("rst_tx_a", bus.tx_a, 0);

    reset = 1'b0;
    tick();
    chk("t1_ready", bus.pin_in_ready, 1);
    chk("t1_rx_v", bus.rx_v, 0);
    chk("t1_out_valid", bus.pin_out_valid, 0);

    // Single word, valid held high to show ready stays low.
    pin_send(21'h15A5A5, 1'b0, 3);
    chk("t2_rx_v", bus.rx_v, 1);
    chk("t2_rx_count", bus.rx_count, 1);
    rx_pop();
    chk("t2_count_after_pop", bus.rx_count, 0);

    // Fill the FIFO, then one pop reopens ready.
    for (int i = 0; i < DEPTH; i++) pin_send(IN_W'(32'h1000 + i * 32'h11111), 1'b0, 0);
    repeat (4) tick();
    chk("t3_full_ready", bus.pin_in_ready, 0);
    chk("t3_full_count", bus.rx_count, DEPTH);
    rx_pop();
    chk("t3_reopen", bus.pin_in_ready, 1);
    chk("t3_count", bus.rx_count, DEPTH - 1);
    pin_send(21'h1FFFFF, 1'b0, 0);
    chk("t3_count_5th", bus.rx_count, DEPTH);
    for (int i = 0; i < DEPTH; i++) rx_pop();
    chk("t3_empty", bus.rx_v, 0);

    tx_send(34'h3_0000_0001, 1'b0);
    tx_send(34'h2_AAAA_5555, 1'b1);
    tx_send(34'h0_0000_0000, 1'b0);
    tx_send(34'h3_FFFF_FFFF, 1'b0);

    // Simultaneous push/pop at count 2, enough words to wrap the pointers.
    pin_send(21'h0ABCDE, 1'b0, 0);
    pin_send(21'h154321, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      w = IN_W'($urandom);
      pin_send(w, 1'b1, 0);
      chk("t5_count", bus.rx_count, 2);
    end
    rx_pop();
    rx_pop();
    chk("t5_drained", bus.rx_count, 0);

    // Reset with a word in the FIFO and valid high on the TX pins.
    pin_send(21'h0C0FFE, 1'b0, 0);
    bus.pin_out_ready = 1'b1;
    repeat (LAT + 1) tick();
    bus.tx_v = 1'b1;
    bus.tx_d = 34'h1_2345_6789;
    tick();
    bus.tx_v = 1'b0;
    n = 0;
    while (bus.pin_out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_valid_up", bus.pin_out_valid, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", bus.pin_out_valid, 0);
    chk("t6_rst_data", bus.pin_out_data, 0);
    chk("t6_rst_count", bus.rx_count, 0);
    chk("t6_rst_rx_v", bus.rx_v, 0);
    chk("t6_rst_ready", bus.pin_in_ready, 0);
    rx_q.delete();
    bus.pin_out_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("t6_ready_after", bus.pin_in_ready, 1);
    pin_send(21'h0BEEF1, 1'b0, 0);
    rx_pop();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
